// File: rtl/bicycle_pkg.sv
// Shared definitions for the two-field digit display loader.
// Holds digit counts, the blank code, field/BCD widths and the loader FSM
// state encoding used by sh_ram_loader and bin2bcd5_seq.
package bicycle_pkg;

  localparam int         NUM_DIGITS   = 10;
  localparam int         FIELD_DIGITS = 5;
  localparam logic [3:0] DIGIT_BLANK  = 4'hF;
  localparam int         VAL_W        = 17;
  localparam int         BCD_W        = 4 * FIELD_DIGITS;
  localparam int         SHIFT_BITS   = 17;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    SHIFT_A = 3'd2,
    STORE_A = 3'd3,
    LOAD_B  = 3'd4,
    SHIFT_B = 3'd5,
    STORE_B = 3'd6
  } state_t;

endpackage

// File: rtl/bin2bcd5_seq.sv
// Sequential 17-bit binary to 5-digit BCD converter (shift-add-3, MSB first,
// one bit per run cycle).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture bin and clear the BCD accumulator
//   run         perform one shift step (ignored once all bits are consumed)
//   bin         binary input (must be <= 99999 to fit five digits)
//   bcd         packed digits, most significant digit in bcd[19:16]
//   ready       all 17 bits have been shifted in, bcd is final
module bin2bcd5_seq
  import bicycle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [VAL_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             ready
);

  logic [VAL_W-1:0] sr;
  logic [4:0]       cnt;
  logic [BCD_W-1:0] adj;

  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < FIELD_DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj   = add3_digits(bcd);
  assign ready = (cnt == 5'(SHIFT_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= bin;
      bcd <= '0;
      cnt <= '0;
    end else if (run && !ready) begin
      bcd <= {adj[BCD_W-2:0], sr[VAL_W-1]};
      sr  <= {sr[VAL_W-2:0], 1'b0};
      cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/sh_ram_loader.sv
// Converts two binary fields to BCD and publishes them atomically into a
// 10-digit display register file (digits 0-4 field A, 5-9 field B).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle request; accepted only in IDLE
//   value_a, value_b  binary field values, clamped to SAT_MAX at capture
//   rd_addr, rd_data  combinational display read; addresses 10-15 read 0
//   busy              high while a conversion is running
//   done              one-cycle pulse on the cycle new digits become visible
module sh_ram_loader
  import bicycle_pkg::*;
#(
  parameter bit               BLANK_LZ = 1'b1,
  parameter logic [VAL_W-1:0] SAT_MAX  = 17'd99999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] value_a,
  input  logic [VAL_W-1:0] value_b,
  input  logic [3:0]       rd_addr,
  output logic [3:0]       rd_data,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [4:0]       shift_cnt;
  logic [VAL_W-1:0] a_cap;
  logic [VAL_W-1:0] b_cap;
  logic [3:0]       stage [NUM_DIGITS];
  logic [3:0]       disp  [NUM_DIGITS];

  logic             conv_load;
  logic             conv_run;
  logic             conv_ready;
  logic [VAL_W-1:0] conv_bin;
  logic [BCD_W-1:0] conv_bcd;
  logic [BCD_W-1:0] blank_a;
  logic [BCD_W-1:0] blank_b;

  function automatic logic [VAL_W-1:0] sat_field(input logic [VAL_W-1:0] v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  // Replace a run of leading zeros with the blank code, examining only the
  // first n digits (the field's least significant digits always stay).
  function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] d, input int n);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = d;
    lead = 1'b1;
    for (int i = 0; i < FIELD_DIGITS - 1; i++) begin
      if (i < n) begin
        lead = lead && (d[BCD_W-1-4*i -: 4] == 4'd0);
        if (lead && BLANK_LZ) r[BCD_W-1-4*i -: 4] = DIGIT_BLANK;
      end
    end
    return r;
  endfunction

  assign conv_load = (state == LOAD_A) || (state == LOAD_B);
  assign conv_run  = (state == SHIFT_A) || (state == SHIFT_B);
  assign conv_bin  = (state == LOAD_B) ? b_cap : a_cap;
  assign blank_a   = blank_lead(conv_bcd, 4);
  assign blank_b   = blank_lead(conv_bcd, 2);

  bin2bcd5_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (conv_load),
    .run   (conv_run),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .ready (conv_ready)
  );

  always_comb begin
    rd_data = 4'h0;
    if (rd_addr < 4'(NUM_DIGITS)) rd_data = disp[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_cap     <= '0;
      b_cap     <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        stage[i] <= 4'h0;
        disp[i]  <= 4'h0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_cap <= sat_field(value_a);
            b_cap <= sat_field(value_b);
            busy  <= 1'b1;
            state <= LOAD_A;
          end
        end
        LOAD_A: begin
          shift_cnt <= '0;
          state     <= SHIFT_A;
        end
        SHIFT_A: begin
          if (shift_cnt == 5'(SHIFT_BITS - 1)) begin
            shift_cnt <= '0;
            state     <= STORE_A;
          end else begin
            shift_cnt <= shift_cnt + 5'd1;
          end
        end
        STORE_A: begin
          if (conv_ready) begin
            for (int i = 0; i < FIELD_DIGITS; i++)
              stage[i] <= blank_a[BCD_W-1-4*i -: 4];
          end
          state <= LOAD_B;
        end
        LOAD_B: begin
          shift_cnt <= '0;
          state     <= SHIFT_B;
        end
        SHIFT_B: begin
          if (shift_cnt == 5'(SHIFT_BITS - 1)) begin
            shift_cnt <= '0;
            state     <= STORE_B;
          end else begin
            shift_cnt <= shift_cnt + 5'd1;
          end
        end
        STORE_B: begin
          // Field B goes into staging and, together with staged field A,
          // into the display on the same edge so readers never see a mix.
          if (conv_ready) begin
            for (int i = 0; i < FIELD_DIGITS; i++) begin
              stage[FIELD_DIGITS+i] <= blank_b[BCD_W-1-4*i -: 4];
              disp[i]               <= stage[i];
              disp[FIELD_DIGITS+i]  <= blank_b[BCD_W-1-4*i -: 4];
            end
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
